// File: rtl/uart_baud_pkg.sv
// Shared rate-select codes and default preset divisors for the UART baud path.
package uart_baud_pkg;

    localparam logic [1:0] RATE_SEL_0      = 2'b00;
    localparam logic [1:0] RATE_SEL_1      = 2'b01;
    localparam logic [1:0] RATE_SEL_2      = 2'b10;
    localparam logic [1:0] RATE_SEL_CUSTOM = 2'b11;

    // Os period is divisor+1 clocks; the TX/RX FSMs assume these same defaults.
    localparam int DEF_RATE0_DIV  = 31;
    localparam int DEF_RATE1_DIV  = 15;
    localparam int DEF_RATE2_DIV  = 7;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_DIV_W      = 16;

endpackage

// File: rtl/baud_prescaler.sv
// Divide-by-(div+1) prescaler: counts enabled clocks and emits a registered
// single-cycle tick on the clock where the count reaches the divisor.
module baud_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_fire,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_tick;
    logic             w_at_div;

    // Compare before increment, so the maximum divisor never wraps the counter.
    assign w_at_div = (r_cnt == i_div);
    assign o_fire   = i_en && !i_clr && w_at_div;
    assign o_tick   = r_tick;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (i_en) begin
            if (w_at_div) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + DIV_W'(1);
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/baud_tick_gen.sv
// Programmable baud tick generator: oversampling tick, mid-bit strobe and
// bit-rate tick from a preset or custom divisor, with enable and RX resync.
module baud_tick_gen
    import uart_baud_pkg::*;
#(
    parameter int DIV_W      = DEF_DIV_W,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int RATE0_DIV  = DEF_RATE0_DIV,
    parameter int RATE1_DIV  = DEF_RATE1_DIV,
    parameter int RATE2_DIV  = DEF_RATE2_DIV
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_cfg_load,
    input  logic [1:0]       i_cfg_sel,
    input  logic [DIV_W-1:0] i_cfg_div,
    input  logic             i_resync,
    output logic             o_os_tick,
    output logic             o_mid_tick,
    output logic             o_tx_tick,
    output logic [DIV_W-1:0] o_div_cur
);

    localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

    localparam logic [DIV_W-1:0] P_RATE0 = DIV_W'(RATE0_DIV);
    localparam logic [DIV_W-1:0] P_RATE1 = DIV_W'(RATE1_DIV);
    localparam logic [DIV_W-1:0] P_RATE2 = DIV_W'(RATE2_DIV);

    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

    // A preset that does not fit the divisor register is a configuration bug.
    if ((longint'(RATE0_DIV) >> DIV_W) != 0 || RATE0_DIV < 0) begin : g_bad_rate0
        $error("baud_tick_gen: RATE0_DIV does not fit in DIV_W bits");
    end
    if ((longint'(RATE1_DIV) >> DIV_W) != 0 || RATE1_DIV < 0) begin : g_bad_rate1
        $error("baud_tick_gen: RATE1_DIV does not fit in DIV_W bits");
    end
    if ((longint'(RATE2_DIV) >> DIV_W) != 0 || RATE2_DIV < 0) begin : g_bad_rate2
        $error("baud_tick_gen: RATE2_DIV does not fit in DIV_W bits");
    end
    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("baud_tick_gen: OVERSAMPLE must be even and at least 4");
    end

    logic [DIV_W-1:0] r_div;
    logic [OS_W-1:0]  r_os_cnt;
    logic             r_mid_tick;
    logic             r_tx_tick;

    logic [DIV_W-1:0] w_sel_div;
    logic             w_clr;
    logic             w_fire;
    logic             w_os_tick;

    always_comb begin
        w_sel_div = P_RATE0;
        case (i_cfg_sel)
            RATE_SEL_0:      w_sel_div = P_RATE0;
            RATE_SEL_1:      w_sel_div = P_RATE1;
            RATE_SEL_2:      w_sel_div = P_RATE2;
            RATE_SEL_CUSTOM: w_sel_div = i_cfg_div;
            default:         w_sel_div = P_RATE0;
        endcase
    end

    // Load and resync both restart the bit phase; load also swaps the divisor.
    assign w_clr = i_cfg_load || i_resync;

    baud_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_clr),
        .i_en   (i_en),
        .i_div  (r_div),
        .o_fire (w_fire),
        .o_tick (w_os_tick)
    );

    // Mid/tx decode the pre-advance os count so they line up with the os tick.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div      <= P_RATE0;
            r_os_cnt   <= '0;
            r_mid_tick <= 1'b0;
            r_tx_tick  <= 1'b0;
        end else begin
            r_mid_tick <= 1'b0;
            r_tx_tick  <= 1'b0;
            if (i_cfg_load) begin
                r_div    <= w_sel_div;
                r_os_cnt <= '0;
            end else if (i_resync) begin
                r_os_cnt <= '0;
            end else if (w_fire) begin
                r_os_cnt   <= (r_os_cnt == OS_LAST) ? '0 : r_os_cnt + OS_W'(1);
                r_tx_tick  <= (r_os_cnt == OS_LAST);
                r_mid_tick <= (r_os_cnt == OS_MID);
            end
        end
    end

    assign o_os_tick  = w_os_tick;
    assign o_mid_tick = r_mid_tick;
    assign o_tx_tick  = r_tx_tick;
    assign o_div_cur  = r_div;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Self-checking bench for baud_tick_gen: directed latency cases plus random
// stimulus, all checked each cycle against an enabled-clock-count model.
module tb_baud_tick_gen;
    import uart_baud_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        cfg_load = 1'b0;
    logic [1:0]  cfg_sel = 2'b00;
    logic [15:0] cfg_div = 16'd0;
    logic        resync = 1'b0;
    logic        os_tick;
    logic        mid_tick;
    logic        tx_tick;
    logic [15:0] div_cur;

    int total = 0;
    int bad   = 0;

    // Model state: enabled clocks since last restart and divisor in effect.
    longint m_e = 0;
    int     m_d = 31;
    logic   m_os = 1'b0, m_mid = 1'b0, m_tx = 1'b0;

    baud_tick_gen dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_cfg_load (cfg_load),
        .i_cfg_sel  (cfg_sel),
        .i_cfg_div  (cfg_div),
        .i_resync   (resync),
        .o_os_tick  (os_tick),
        .o_mid_tick (mid_tick),
        .o_tx_tick  (tx_tick),
        .o_div_cur  (div_cur)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int preset_div(input logic [1:0] sel, input logic [15:0] d);
        case (sel)
            2'b00:   return 31;
            2'b01:   return 15;
            2'b10:   return 7;
            default: return int'(d);
        endcase
    endfunction

    // One clock: model consumes the same inputs the DUT sampled, then compare.
    task automatic tick(input string tag);
        longint p;
        longint k;
        @(posedge clk);
        m_os = 1'b0; m_mid = 1'b0; m_tx = 1'b0;
        if (rst) begin
            m_e = 0;
            m_d = 31;
        end else if (cfg_load) begin
            m_d = preset_div(cfg_sel, cfg_div);
            m_e = 0;
        end else if (resync) begin
            m_e = 0;
        end else if (en) begin
            m_e++;
            p = longint'(m_d) + 1;
            if (m_e % p == 0) begin
                k     = m_e / p;
                m_os  = 1'b1;
                m_mid = (k % 16 == 8);
                m_tx  = (k % 16 == 0);
            end
        end
        @(negedge clk);
        chk(tag, longint'({os_tick, mid_tick, tx_tick, div_cur}),
            longint'({m_os, m_mid, m_tx, m_d[15:0]}));
    endtask

    task automatic set_in(input logic r, input logic e, input logic ld,
                          input logic [1:0] s, input logic [15:0] d, input logic rs);
        rst = r; en = e; cfg_load = ld; cfg_sel = s; cfg_div = d; resync = rs;
    endtask

    task automatic load(input logic [1:0] s, input logic [15:0] d);
        set_in(1'b0, 1'b1, 1'b1, s, d, 1'b0);
        tick("load");
        set_in(1'b0, 1'b1, 1'b0, s, d, 1'b0);
    endtask

    // Count enabled clocks until the chosen output fires; budget+1 on timeout.
    task automatic run_until(input int which, input int budget, output int n);
        logic hit;
        set_in(1'b0, 1'b1, 1'b0, cfg_sel, cfg_div, 1'b0);
        n = 0;
        hit = 1'b0;
        while (!hit && n <= budget) begin
            tick("run");
            n++;
            hit = (which == 0) ? os_tick : (which == 1) ? mid_tick : tx_tick;
        end
    endtask

    initial begin
        int n;

        // Reset, then defaults: os every 32, mid at 256, tx at 512.
        repeat (3) tick("reset");
        chk("rst_div", div_cur, 31);
        chk("rst_ticks", {os_tick, mid_tick, tx_tick}, 0);
        run_until(0, 100, n);  chk("def_first_os", n, 32);
        run_until(1, 600, n);  chk("def_first_mid", n, 256 - 32);
        run_until(2, 600, n);  chk("def_first_tx", n, 512 - 256);
        run_until(2, 600, n);  chk("def_tx_period", n, 512);

        // Preset 2.
        load(RATE_SEL_2, 16'd0);
        chk("load2_div", div_cur, 7);
        chk("load2_no_tick", os_tick, 0);
        run_until(0, 100, n);  chk("r2_first_os", n, 8);
        run_until(2, 200, n);  chk("r2_first_tx", n, 128 - 8);
        run_until(2, 200, n);  chk("r2_tx_period", n, 128);

        // Custom divide-by-1, then maximum divisor.
        load(RATE_SEL_CUSTOM, 16'd0);
        chk("c0_div", div_cur, 0);
        run_until(0, 10, n);   chk("c0_os", n, 1);
        run_until(0, 10, n);   chk("c0_os_again", n, 1);
        run_until(2, 40, n);   chk("c0_first_tx", n, 14);
        run_until(2, 40, n);   chk("c0_tx_period", n, 16);
        load(RATE_SEL_CUSTOM, 16'hFFFF);
        chk("cmax_div", div_cur, 65535);
        run_until(0, 66000, n); chk("cmax_first_os", n, 65536);

        // Enable low for 10 clocks mid-bit delays the next os tick by 10.
        load(RATE_SEL_1, 16'd0);
        repeat (5) tick("en_pre");
        set_in(1'b0, 1'b0, 1'b0, cfg_sel, cfg_div, 1'b0);
        repeat (10) tick("en_low");
        run_until(0, 40, n);   chk("en_resume_os", n, 16 - 5);

        // Resync at os_cnt 11, then resync together with load.
        load(RATE_SEL_1, 16'd0);
        for (int i = 0; i < 11; i++) begin
            run_until(0, 40, n); chk("rs_os_period", n, 16);
        end
        set_in(1'b0, 1'b1, 1'b0, cfg_sel, cfg_div, 1'b1);
        tick("resync");
        chk("rs_no_tick", {os_tick, mid_tick, tx_tick}, 0);
        run_until(1, 300, n);  chk("rs_mid", n, 8 * 16);
        set_in(1'b0, 1'b1, 1'b1, RATE_SEL_2, 16'd0, 1'b1);
        tick("rs_load");
        chk("rs_load_div", div_cur, 7);
        run_until(0, 40, n);   chk("rs_load_os", n, 8);

        // Reset lands on the edge where tx is due.
        load(RATE_SEL_2, 16'd0);
        repeat (127) tick("pre_rst");
        set_in(1'b1, 1'b1, 1'b0, cfg_sel, cfg_div, 1'b0);
        tick("rst_on_tx");
        chk("rst_drop_tx", tx_tick, 0);
        chk("rst_div_back", div_cur, 31);

        // Random traffic, small custom divisors so ticks occur often.
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom_range(0, 255) == 0),
                   ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 63) == 0),
                   2'($urandom_range(0, 3)),
                   16'($urandom_range(0, 20)),
                   ($urandom_range(0, 63) == 0));
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
